instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the immediate decoder. Packs RV32I fields (format, opcode, registers, functs, full 32-bit immediate) into a 32-bit instruction word.
- Range-checks the immediate against the selected format.
- Two-stage valid/ready pipeline. Feeds the instruction-memory loader and test harness, so each word carries a running write address.

Parameters:
- BASE_ADDR, 32'h0000_0000, first ADDRESS value after reset or CLEAR.
- ADDR_STEP, 4, ADDRESS increment per output handshake.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- CLEAR  input  1  synchronous flush of pipeline and address counter.
- IN_VALID  input  1  input fields valid.
- IN_READY  output  1  encoder accepts input this cycle.
- FORMAT  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- OPCODE  input  7  passed to INSTRUCTION[6:0] unchecked.
- RD, RS1, RS2  input  5 each  register indices.
- FUNCT3  input  3; FUNCT7  input  7.
- IMM  input  32  immediate as the decoder would output it: sign-extended value for I/S/B/J, upper value with [11:0]=0 for U.
- OUT_VALID  output  1  INSTRUCTION valid.
- OUT_READY  input  1  downstream accepts.
- INSTRUCTION  output  32  encoded word.
- ADDRESS  output  32  write address associated with INSTRUCTION.
- RANGE_ERROR  output  1  qualifies INSTRUCTION: immediate not representable, or illegal FORMAT.
- ERR_COUNT  output  8  saturating count of errored words handed off.

Behaviour:
- Reset: RESET is synchronous, active-high, on CLK. It has priority over everything.
  - OUT_VALID=0, INSTRUCTION=0, RANGE_ERROR=0, ERR_COUNT=0, ADDRESS=BASE_ADDR.
  - Both stage-valid flags cleared. IN_READY=0 while RESET is high.
- Stages:
  - S1 registers the fields and computes the range check.
  - S2 registers the assembled word and the error flag, and drives the outputs.
- Latency: 2 cycles from input handshake to OUT_VALID with no backpressure. Throughput is 1 word per cycle.
- Handshake advance rules:
  - s2_adv = !OUT_VALID | OUT_READY.
  - s1_adv = !s1_valid | s2_adv.
  - IN_READY = s1_adv & !CLEAR & !RESET.
  - Input transfers on IN_VALID & IN_READY. Output transfers on OUT_VALID & OUT_READY.
- While OUT_VALID=1 and OUT_READY=0, INSTRUCTION, ADDRESS and RANGE_ERROR hold stable. No loss, no duplication.
- Encoding (standard RV32I):
  - R: {FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE}.
  - I: {IMM[11:0], RS1, FUNCT3, RD, OPCODE}.
  - S: {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE}.
  - B: {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE}.
  - U: {IMM[31:12], RD, OPCODE}.
  - J: {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE}.
  - Illegal FORMAT: INSTRUCTION=32'h0000_0000.
- Range check (RANGE_ERROR=1 when violated):
  - I/S: IMM must equal sign-extension of IMM[11:0], i.e. -2048..2047.
  - B: IMM equals sign-extension of IMM[12:0] and IMM[0]=0, i.e. -4096..4094 even.
  - J: IMM equals sign-extension of IMM[20:0] and IMM[0]=0.
  - U: IMM[11:0]=0.
  - R: IMM ignored, never errors.
  - Illegal FORMAT: always errors.
  - An errored word is still emitted, encoded from truncated bits.
- ADDRESS:
  - Value of the counter at the moment the word is emitted.
  - Counter += ADDR_STEP on each output handshake and wraps modulo 2^32.
- ERR_COUNT: +1 on each output handshake with RANGE_ERROR=1; saturates at 255.
- CLEAR (synchronous):
  - Drops S1 and S2 contents; OUT_VALID=0 next cycle.
  - ADDRESS=BASE_ADDR. ERR_COUNT is retained.
  - Blocks input that cycle.
  - A handshake coincident with CLEAR counts for ERR_COUNT, but the address reset wins.
- Reset mid-stream: all in-flight words are discarded and no output handshake occurs afterwards. Same for CLEAR.

Test Plan:
- addi x1,x0,-1: FORMAT=1, OPCODE=7'b0010011, RD=1, RS1=0, FUNCT3=0, IMM=32'hFFFFFFFF -> 2 cycles later INSTRUCTION=32'hFFF00093, ADDRESS=BASE_ADDR, RANGE_ERROR=0.
- Back-to-back stream, each word expected with RANGE_ERROR=0 and ADDRESS stepping by 4:
  - sw x2,8(x1): FORMAT=2, IMM=8 -> 32'h0020A423.
  - beq x0,x0,-4: FORMAT=3, IMM=-4 -> 32'hFE000EE3.
  - jal x1,2048: FORMAT=5, IMM=32'h800 -> 32'h001000EF.
  - lui x5,0x12345: FORMAT=4, IMM=32'h12345000 -> 32'h123452B7.
- Range errors, ERR_COUNT reaching 4, all other words unaffected:
  - I-type IMM=2048.
  - B-type IMM=3.
  - U-type IMM=32'h00000001.
  - FORMAT=7 -> INSTRUCTION=0.
- Backpressure: 5-word stream with OUT_READY low for cycles 3-6.
  - IN_READY drops once S1 and S2 are full.
  - Outputs stay stable while stalled.
  - All 5 words arrive in order, no duplicates. Final ADDRESS = BASE_ADDR+16.
- CLEAR with 2 words in flight -> OUT_VALID=0 next cycle, next accepted word emitted at ADDRESS=BASE_ADDR, ERR_COUNT unchanged. Then RESET mid-stream -> every output at its reset value.
- Wrap and saturation:
  - BASE_ADDR=32'hFFFFFFFC, two words -> ADDRESS sequence FFFFFFFC, 00000000.
  - 300 errored words -> ERR_COUNT holds 255.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs format/opcode/register/funct/immediate
// fields into a 32-bit instruction word, flags immediates that the selected
// format cannot represent, and tags every emitted word with a running write
// address for the instruction-memory loader.
// Two-stage valid/ready pipeline: S1 holds the fields plus the range verdict,
// S2 holds the assembled word and drives the outputs.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ADDR_STEP = 32'd4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CLEAR,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [2:0]  FORMAT,
   input  logic [6:0]  OPCODE,
   input  logic [4:0]  RD,
   input  logic [4:0]  RS1,
   input  logic [4:0]  RS2,
   input  logic [2:0]  FUNCT3,
   input  logic [6:0]  FUNCT7,
   input  logic [31:0] IMM,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] INSTRUCTION,
   output logic [31:0] ADDRESS,
   output logic        RANGE_ERROR,
   output logic [7:0]  ERR_COUNT
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   // True when the immediate cannot be carried by the selected format.
   // Formats 6/7 are not instruction formats at all and always error.
   function automatic logic imm_range_err(input logic [2:0] fmt, input logic [31:0] imm);
      logic err;
      err = 1'b0;
      case (fmt)
         FMT_R:        err = 1'b0;
         FMT_I, FMT_S: err = (imm[31:11] != {21{imm[11]}});
         FMT_B:        err = (imm[31:12] != {20{imm[12]}}) | imm[0];
         FMT_U:        err = (imm[11:0] != 12'h000);
         FMT_J:        err = (imm[31:20] != {12{imm[20]}}) | imm[0];
         default:      err = 1'b1;
      endcase
      return err;
   endfunction

   // Standard RV32I bit placement; out-of-range immediates are simply
   // truncated to the bits the format has room for.
   function automatic logic [31:0] encode_word(
      input logic [2:0]  fmt,
      input logic [6:0]  op,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [2:0]  f3,
      input logic [6:0]  f7,
      input logic [31:0] imm
   );
      logic [31:0] w;
      w = 32'h0000_0000;
      case (fmt)
         FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
         FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
         FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         FMT_U:   w = {imm[31:12], rd, op};
         FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   // Stage 1 state
   logic        s1_valid_q, s1_valid_d;
   logic [2:0]  s1_fmt_q,   s1_fmt_d;
   logic [6:0]  s1_op_q,    s1_op_d;
   logic [4:0]  s1_rd_q,    s1_rd_d;
   logic [4:0]  s1_rs1_q,   s1_rs1_d;
   logic [4:0]  s1_rs2_q,   s1_rs2_d;
   logic [2:0]  s1_f3_q,    s1_f3_d;
   logic [6:0]  s1_f7_q,    s1_f7_d;
   logic [31:0] s1_imm_q,   s1_imm_d;
   logic        s1_err_q,   s1_err_d;

   // Stage 2 / output state
   logic        out_valid_q, out_valid_d;
   logic [31:0] word_q,      word_d;
   logic        rerr_q,      rerr_d;
   logic [31:0] addr_q,      addr_d;
   logic [7:0]  err_cnt_q,   err_cnt_d;

   // Handshake terms
   logic        s2_adv_s;
   logic        s1_adv_s;
   logic        in_ready_s;
   logic        in_fire_s;
   logic        out_fire_s;
   logic        s2_load_s;
   logic [31:0] s1_word_s;

   // Pipeline advance conditions and handshakes.
   always_comb begin
      s2_adv_s   = ~out_valid_q | OUT_READY;
      s1_adv_s   = ~s1_valid_q | s2_adv_s;
      in_ready_s = s1_adv_s & ~CLEAR & ~RESET;
      in_fire_s  = IN_VALID & in_ready_s;
      out_fire_s = out_valid_q & OUT_READY;
      s2_load_s  = s2_adv_s & s1_valid_q & ~CLEAR;
      s1_word_s  = encode_word(s1_fmt_q, s1_op_q, s1_rd_q, s1_rs1_q, s1_rs2_q,
                               s1_f3_q, s1_f7_q, s1_imm_q);
   end

   // Next state for both stages, the address counter and the error counter.
   // CLEAR empties both stages and rewinds the address, but a handshake in
   // the same cycle still counts toward the error total.
   always_comb begin
      s1_fmt_d = in_fire_s ? FORMAT : s1_fmt_q;
      s1_op_d  = in_fire_s ? OPCODE : s1_op_q;
      s1_rd_d  = in_fire_s ? RD     : s1_rd_q;
      s1_rs1_d = in_fire_s ? RS1    : s1_rs1_q;
      s1_rs2_d = in_fire_s ? RS2    : s1_rs2_q;
      s1_f3_d  = in_fire_s ? FUNCT3 : s1_f3_q;
      s1_f7_d  = in_fire_s ? FUNCT7 : s1_f7_q;
      s1_imm_d = in_fire_s ? IMM    : s1_imm_q;
      s1_err_d = in_fire_s ? imm_range_err(FORMAT, IMM) : s1_err_q;

      word_d   = s2_load_s ? s1_word_s : word_q;
      rerr_d   = s2_load_s ? s1_err_q  : rerr_q;

      if (CLEAR) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
         addr_d      = BASE_ADDR;
      end else begin
         s1_valid_d  = s1_adv_s ? in_fire_s  : s1_valid_q;
         out_valid_d = s2_adv_s ? s1_valid_q : out_valid_q;
         addr_d      = out_fire_s ? (addr_q + ADDR_STEP) : addr_q;
      end

      if (out_fire_s && rerr_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // State registers with synchronous reset taking priority.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1_valid_q  <= 1'b0;
         s1_fmt_q    <= 3'd0;
         s1_op_q     <= 7'd0;
         s1_rd_q     <= 5'd0;
         s1_rs1_q    <= 5'd0;
         s1_rs2_q    <= 5'd0;
         s1_f3_q     <= 3'd0;
         s1_f7_q     <= 7'd0;
         s1_imm_q    <= 32'h0000_0000;
         s1_err_q    <= 1'b0;
         out_valid_q <= 1'b0;
         word_q      <= 32'h0000_0000;
         rerr_q      <= 1'b0;
         addr_q      <= BASE_ADDR;
         err_cnt_q   <= 8'd0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_fmt_q    <= s1_fmt_d;
         s1_op_q     <= s1_op_d;
         s1_rd_q     <= s1_rd_d;
         s1_rs1_q    <= s1_rs1_d;
         s1_rs2_q    <= s1_rs2_d;
         s1_f3_q     <= s1_f3_d;
         s1_f7_q     <= s1_f7_d;
         s1_imm_q    <= s1_imm_d;
         s1_err_q    <= s1_err_d;
         out_valid_q <= out_valid_d;
         word_q      <= word_d;
         rerr_q      <= rerr_d;
         addr_q      <= addr_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign IN_READY    = in_ready_s;
   assign OUT_VALID   = out_valid_q;
   assign INSTRUCTION = word_q;
   assign ADDRESS     = addr_q;
   assign RANGE_ERROR = rerr_q;
   assign ERR_COUNT   = err_cnt_q;

endmodule
